// File: rtl/duty_measure_sequencer.sv
// Duty-cycle measurement sequencer: samples a synchronized waveform once per
// prescaled tick over a fixed window, then divides to a percentage.
// Latency: WINDOW*CLOCK_SCALE cycles in MEASURE + 15 cycles in DIVIDE; result held until ResultAck.
//
// Ports:
//   InputClock_i   - single clock, rising edge
//   ResetN_i       - synchronous active-low reset
//   Start_i        - one-cycle measurement request (honoured in IDLE only)
//   Abort_i        - cancels MEASURE or DIVIDE, previous result retained
//   Signal_i       - asynchronous waveform under measurement
//   ResultAck_i    - releases the presented result (honoured in DONE only)
//   Busy_o         - high in MEASURE and DIVIDE
//   ResultValid_o  - high in DONE
//   HighCount_o    - high samples in the last completed window
//   TotalCount_o   - samples in the last completed window (equals WINDOW)
//   DutyPercent_o  - floor(HighCount*100/WINDOW), 0..100
module duty_measure_sequencer #(
    parameter int unsigned CLOCK_SCALE = 2500,
    parameter int unsigned WINDOW      = 200
) (
    input  logic       InputClock_i,
    input  logic       ResetN_i,
    input  logic       Start_i,
    input  logic       Abort_i,
    input  logic       Signal_i,
    input  logic       ResultAck_i,
    output logic       Busy_o,
    output logic       ResultValid_o,
    output logic [7:0] HighCount_o,
    output logic [7:0] TotalCount_o,
    output logic [6:0] DutyPercent_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [31:0] PRESC_LAST = 32'(CLOCK_SCALE - 1);
    localparam logic [7:0]  WIN        = 8'(WINDOW);
    localparam logic [7:0]  WIN_LAST   = 8'(WINDOW - 1);
    localparam logic [8:0]  WIN9       = {1'b0, WIN};
    // One restoring step per dividend bit.
    localparam logic [3:0]  DIV_LAST   = 4'd14;

    state_t      state_q, state_d;

    logic        sig_meta_q, sig_sync_q;

    logic [31:0] presc_q, presc_d;
    logic [7:0]  sample_q, sample_d;
    logic [7:0]  high_q, high_d;

    logic [7:0]  rem_q, rem_d;
    logic [14:0] quo_q, quo_d;
    logic [3:0]  div_cnt_q, div_cnt_d;

    logic [7:0]  high_out_q, high_out_d;
    logic [7:0]  total_out_q, total_out_d;
    logic [6:0]  duty_out_q, duty_out_d;

    logic        tick;
    logic        final_tick;
    logic        div_last;
    logic [14:0] high_final;
    logic [14:0] dividend;
    logic [8:0]  rem_shift;
    logic        rem_ge;
    logic [14:0] quo_step;
    logic [7:0]  rem_step;

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous input
    // ------------------------------------------------------------------
    always_ff @(posedge InputClock_i) begin
        if (!ResetN_i) begin
            sig_meta_q <= 1'b0;
            sig_sync_q <= 1'b0;
        end else begin
            sig_meta_q <= Signal_i;
            sig_sync_q <= sig_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge InputClock_i) begin
        if (!ResetN_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign tick       = (state_q == MEASURE) && (presc_q == PRESC_LAST);
    assign final_tick = tick && (sample_q == WIN_LAST);
    assign div_last   = (state_q == DIVIDE) && (div_cnt_q == DIV_LAST);

    // ------------------------------------------------------------------
    // FSM: next-state logic. Abort is checked before the final tick and
    // the last divide step so a coincident abort never reaches DIVIDE/DONE.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (Start_i) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (Abort_i) begin
                    state_d = IDLE;
                end else if (final_tick) begin
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                if (Abort_i) begin
                    state_d = IDLE;
                end else if (div_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ResultAck_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        Busy_o        = 1'b0;
        ResultValid_o = 1'b0;
        unique case (state_q)
            MEASURE: Busy_o        = 1'b1;
            DIVIDE:  Busy_o        = 1'b1;
            DONE:    ResultValid_o = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Divider step: shift in the next dividend bit, subtract if it fits.
    // Remainder stays below WINDOW, so 8 bits hold it between steps.
    // ------------------------------------------------------------------
    assign high_final = 15'(high_q) + 15'(sig_sync_q);
    assign dividend   = high_final * 15'd100;
    assign rem_shift  = {rem_q, quo_q[14]};
    assign rem_ge     = (rem_shift >= WIN9);
    assign rem_step   = rem_ge ? 8'(rem_shift - WIN9) : rem_shift[7:0];
    assign quo_step   = {quo_q[13:0], rem_ge};

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        presc_d     = presc_q;
        sample_d    = sample_q;
        high_d      = high_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_cnt_d   = div_cnt_q;
        high_out_d  = high_out_q;
        total_out_d = total_out_q;
        duty_out_d  = duty_out_q;

        unique case (state_q)
            IDLE: begin
                // Held clear so MEASURE always starts from zero.
                presc_d   = '0;
                sample_d  = '0;
                high_d    = '0;
                div_cnt_d = '0;
            end
            MEASURE: begin
                if (tick) begin
                    presc_d  = '0;
                    sample_d = sample_q + 8'd1;
                    high_d   = high_q + 8'(sig_sync_q);
                end else begin
                    presc_d = presc_q + 32'd1;
                end
                if (final_tick) begin
                    rem_d     = '0;
                    quo_d     = dividend;
                    div_cnt_d = '0;
                end
            end
            DIVIDE: begin
                rem_d     = rem_step;
                quo_d     = quo_step;
                div_cnt_d = div_cnt_q + 4'd1;
                // Results publish only on the DONE-entry edge, all together.
                if (div_last && !Abort_i) begin
                    high_out_d  = high_q;
                    total_out_d = sample_q;
                    duty_out_d  = quo_step[6:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge InputClock_i) begin
        if (!ResetN_i) begin
            presc_q     <= '0;
            sample_q    <= '0;
            high_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_cnt_q   <= '0;
            high_out_q  <= '0;
            total_out_q <= '0;
            duty_out_q  <= '0;
        end else begin
            presc_q     <= presc_d;
            sample_q    <= sample_d;
            high_q      <= high_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_cnt_q   <= div_cnt_d;
            high_out_q  <= high_out_d;
            total_out_q <= total_out_d;
            duty_out_q  <= duty_out_d;
        end
    end

    assign HighCount_o   = high_out_q;
    assign TotalCount_o  = total_out_q;
    assign DutyPercent_o = duty_out_q;

endmodule
